qpp_addr_gen: RTL and testbench
===============================

// Module: qpp_addr_gen
// PURPOSE
//  Generates the QPP turbo-interleaver sequence pi(i) = (f1*i + f2*i^2) mod K, i = 0..K-1.
//  Each pi(i) is split into a bank index (0..7) and an in-bank offset for the 8 parallel SISO windows.
//  Sits directly upstream of the 8-lane interleave mux: bank_id drives its resortSE_id select.
//  offset addresses the extrinsic RAM banks that fill the mux's 8-lane data input.
// PARAMETERS
//  K_W    13   width of K, f1, f2, pi (K <= 6144)
//  NBANK  8    bank count; fixed, bank_id is 3 bits
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      pulse: latch K/f1/f2, begin a new sequence (also aborts a running one)
//  k_in       in   K_W    block size K, multiple of 8, 40..6144
//  f1_in      in   K_W    QPP f1, < K
//  f2_in      in   K_W    QPP f2, < K
//  en         in   1      advance enable; 0 freezes every register except reset/start handling
//  busy       out  1      high from the cycle after start until the cycle after the last output
//  out_valid  out  1      bank_id/offset/pi_out valid this cycle
//  pi_out     out  K_W    pi(i)
//  bank_id    out  3      floor(pi(i) / M), M = K/8
//  offset     out  K_W-3  pi(i) - bank_id*M
//  last       out  1      coincides with out_valid for i = K-1
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal pi, g, counters 0.
//  FSM: IDLE -start-> SETUP -> RUN -(i==K-1 issued)-> IDLE.
//  start in any state (RUN included) restarts into SETUP; in-flight outputs are squashed (out_valid=0 next cycle).
//  SETUP (1 cycle, ignores en):
//   - latch K, M=K>>3;
//   - g0 = (f1+f2) mod K and step = (2*f2) mod K, each one add + conditional subtract of K;
//   - thresholds T[j] = j*M, j = 1..7, built by shift-add and registered;
//   - pi=0, i=0.
//  RUN, each cycle with en=1:
//   - stage 1 issues pi(i), then updates pi <= (pi+g) mod K and g <= (g+step) mod K;
//   - every modular add is (a+b) on K_W+1 bits, subtract K if >= K; operands are always < K;
//   - stage 2 registers bank_id = count of T[j] <= pi (7 parallel compares), offset = pi - T[bank_id];
//   - also registers pi_out, out_valid=1, last=(i==K-1).
//  Latency: first out_valid 3 cycles after start (SETUP, stage1, stage2), then one output per en cycle.
//  en=0 holds outputs and pipeline unchanged; out_valid stays as-is (no bubble insertion).
//  After last: state=IDLE, out_valid drops next cycle; busy drops the cycle after last is seen.
//  k_in not a multiple of 8 or f1/f2 >= K: outputs undefined, no hang (returns to IDLE after K outputs).
//  Asynchronous reset mid-run: immediate return to reset values, no output.
// STRUCTURE
//  Shared constants file: NBANK=8, BANK_W=3, K_MAX=6144, K_W default, FSM state encodings.
//  Sub-module: qpp_mod_add (K_W; a, b, K -> (a+b) mod K), used for pi, g, g0, step.
//  Bank split (threshold compare + subtract) stays inline in stage 2.
// TESTING
//  1 K=40,f1=3,f2=10, en=1:
//    - pi = 0,13,6,19,... (pi(1)=13 -> bank 2, offset 3; pi(3)=19 -> bank 3, offset 4);
//    - last on the 40th output; the 40 values are a permutation of 0..39.
//  2 K=6144,f1=263,f2=480:
//    - full run matches a golden model (f1*i + f2*i^2) mod K for all i;
//    - bank histogram is exactly 768 per bank.
//  3 en toggled pseudo-randomly (50%) on K=40:
//    - same output sequence as test 1;
//    - outputs frozen while en=0; no duplicates or drops.
//  4 start reasserted at i=17 with K=48,f1=7,f2=12:
//    - no stale K=40 values after the restart cycle;
//    - new sequence begins 0,19,62 mod 48=14 ...
//  5 rst_n pulsed low mid-run:
//    - all outputs 0 asynchronously, busy=0;
//    - next start gives a clean sequence from pi=0.
//  6 back-to-back start on the cycle after last:
//    - second sequence's first out_valid 3 cycles later; busy never glitches low between.

Source files
------------

// File: rtl/qpp_addr_gen_pkg.sv
// Shared constants and FSM state type for the QPP interleaver address generator.
package qpp_addr_gen_pkg;
  localparam int unsigned NBANK   = 8;
  localparam int unsigned BANK_W  = 3;
  localparam int unsigned K_MAX   = 6144;
  localparam int unsigned K_W_DEF = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } state_e;
endpackage

// File: rtl/qpp_mod_add.sv
// Modular adder (a + b) mod k for operands already reduced below k.
module qpp_mod_add #(
  parameter int unsigned K_W = 13
) (
  input  logic [K_W-1:0] a,
  input  logic [K_W-1:0] b,
  input  logic [K_W-1:0] k,
  output logic [K_W-1:0] s
);
  logic [K_W:0] sum;
  logic         ge;

  // The reduced result is < k, so subtracting on K_W bits wraps to the right value.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    ge  = (sum >= {1'b0, k});
    s   = sum[K_W-1:0] - (ge ? k : '0);
  end
endmodule

// File: rtl/qpp_addr_gen.sv
// QPP turbo-interleaver address generator: pi(i) = (f1*i + f2*i^2) mod K, split into bank/offset.
module qpp_addr_gen
  import qpp_addr_gen_pkg::*;
#(
  parameter int unsigned K_W = K_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_in,
  input  logic [K_W-1:0]    f1_in,
  input  logic [K_W-1:0]    f2_in,
  input  logic              en,
  output logic              busy,
  output logic              out_valid,
  output logic [K_W-1:0]    pi_out,
  output logic [BANK_W-1:0] bank_id,
  output logic [K_W-4:0]    offset,
  output logic              last
);
  state_e state_q, state_d;

  logic [K_W-1:0] k_q, k_d, f1_q, f1_d, f2_q, f2_d;
  logic [K_W-1:0] step_q, step_d, g_q, g_d, pi_q, pi_d, i_q, i_d;
  logic [K_W-1:0] thr_q [1:NBANK-1];
  logic [K_W-1:0] thr_d [1:NBANK-1];

  logic           s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [K_W-1:0] s1_pi_q, s1_pi_d;

  logic              out_valid_q, out_valid_d, last_q, last_d;
  logic [K_W-1:0]    pi_out_q, pi_out_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [K_W-4:0]    offset_q, offset_d;

  logic [K_W-1:0] pi_sum, g_sum, g0_sum, step_sum;
  logic [K_W-1:0] m, base;
  logic [BANK_W-1:0] bank_n;

  qpp_mod_add #(.K_W(K_W)) u_pi   (.a(pi_q), .b(g_q),    .k(k_q), .s(pi_sum));
  qpp_mod_add #(.K_W(K_W)) u_g    (.a(g_q),  .b(step_q), .k(k_q), .s(g_sum));
  qpp_mod_add #(.K_W(K_W)) u_g0   (.a(f1_q), .b(f2_q),   .k(k_q), .s(g0_sum));
  qpp_mod_add #(.K_W(K_W)) u_step (.a(f2_q), .b(f2_q),   .k(k_q), .s(step_sum));

  // Bank split: count thresholds at or below pi, then subtract the selected one.
  always_comb begin
    bank_n = '0;
    for (int unsigned j = 1; j < NBANK; j++) begin
      if (thr_q[j] <= s1_pi_q) bank_n = bank_n + BANK_W'(1);
    end
    base = '0;
    for (int unsigned j = 1; j < NBANK; j++) begin
      if (bank_n == BANK_W'(j)) base = thr_q[j];
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    f1_d        = f1_q;
    f2_d        = f2_q;
    step_d      = step_q;
    g_d         = g_q;
    pi_d        = pi_q;
    i_d         = i_q;
    thr_d       = thr_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_pi_d     = s1_pi_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    pi_out_d    = pi_out_q;
    bank_d      = bank_q;
    offset_d    = offset_q;
    m           = k_q >> 3;

    if (start) begin
      state_d     = ST_SETUP;
      k_d         = k_in;
      f1_d        = f1_in;
      f2_d        = f2_in;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end else begin
      case (state_q)
        ST_SETUP: begin
          step_d   = step_sum;
          g_d      = g0_sum;
          thr_d[1] = m;
          thr_d[2] = m << 1;
          thr_d[3] = (m << 1) + m;
          thr_d[4] = m << 2;
          thr_d[5] = (m << 2) + m;
          thr_d[6] = (m << 2) + (m << 1);
          thr_d[7] = (m << 3) - m;
          pi_d     = '0;
          i_d      = '0;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          if (en) begin
            s1_valid_d = 1'b1;
            s1_pi_d    = pi_q;
            s1_last_d  = (i_q == k_q - K_W'(1));
            pi_d       = pi_sum;
            g_d        = g_sum;
            i_d        = i_q + K_W'(1);
            if (i_q == k_q - K_W'(1)) state_d = ST_IDLE;
          end
        end
        default: begin
          if (en) begin
            s1_valid_d = 1'b0;
            s1_last_d  = 1'b0;
          end
        end
      endcase

      if (en) begin
        out_valid_d = s1_valid_q;
        last_d      = s1_valid_q & s1_last_q;
        if (s1_valid_q) begin
          pi_out_d = s1_pi_q;
          bank_d   = bank_n;
          offset_d = (K_W-3)'(s1_pi_q - base);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      f1_q        <= '0;
      f2_q        <= '0;
      step_q      <= '0;
      g_q         <= '0;
      pi_q        <= '0;
      i_q         <= '0;
      thr_q       <= '{default: '0};
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_pi_q     <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      pi_out_q    <= '0;
      bank_q      <= '0;
      offset_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      f1_q        <= f1_d;
      f2_q        <= f2_d;
      step_q      <= step_d;
      g_q         <= g_d;
      pi_q        <= pi_d;
      i_q         <= i_d;
      thr_q       <= thr_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_pi_q     <= s1_pi_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      pi_out_q    <= pi_out_d;
      bank_q      <= bank_d;
      offset_q    <= offset_d;
    end
  end

  // Busy covers the FSM plus the two pipeline stages still draining.
  assign busy      = (state_q != ST_IDLE) | s1_valid_q | out_valid_q;
  assign out_valid = out_valid_q;
  assign pi_out    = pi_out_q;
  assign bank_id   = bank_q;
  assign offset    = offset_q;
  assign last      = last_q;
endmodule

// File: tb/tb_qpp_addr_gen.sv
// Directed self-checking bench for qpp_addr_gen.
module tb_qpp_addr_gen;
  localparam int K_W  = 13;
  localparam int KMAX = 6144;

  logic            clk = 1'b0;
  logic            rst_n, start, en;
  logic [K_W-1:0]  k_in, f1_in, f2_in;
  logic            busy, out_valid, last;
  logic [K_W-1:0]  pi_out;
  logic [2:0]      bank_id;
  logic [K_W-4:0]  offset;

  int n_checks = 0;
  int n_fail   = 0;

  int obs_pi   [KMAX];
  int obs_bank [KMAX];
  int obs_off  [KMAX];
  bit obs_last [KMAX];

  qpp_addr_gen #(.K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_in(k_in), .f1_in(f1_in), .f2_in(f2_in),
    .en(en), .busy(busy), .out_valid(out_valid), .pi_out(pi_out), .bank_id(bank_id),
    .offset(offset), .last(last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gold(input int k, input int f1, input int f2, input int i);
    longint v;
    v = longint'(f1) * i + longint'(f2) * i * i;
    return int'(v % k);
  endfunction

  task automatic do_start(input int k, input int f1, input int f2);
    k_in  = K_W'(k);
    f1_in = K_W'(f1);
    f2_in = K_W'(f2);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records each new output (en=1 edge with out_valid) until last or the cycle budget runs out.
  task automatic collect(input int k, input bit rnd_en, output int lat, output int nout,
                         output int busy_gaps, output int frozen_bad, output bit timeout);
    logic [27:0] prev;
    bit en_cur;
    bit done;
    int budget;
    done = 0; lat = -1; nout = 0; busy_gaps = 0; frozen_bad = 0;
    budget = 4 * k + 64;
    for (int c = 1; c <= budget && !done; c++) begin
      en_cur = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      en = en_cur;
      prev = {out_valid, pi_out, bank_id, offset, last};
      tick();
      if (!busy && lat < 0) busy_gaps++;
      if (!en_cur) begin
        if ({out_valid, pi_out, bank_id, offset, last} !== prev) frozen_bad++;
      end else if (out_valid) begin
        if (lat < 0) lat = c;
        if (nout < KMAX) begin
          obs_pi[nout]   = int'(pi_out);
          obs_bank[nout] = int'(bank_id);
          obs_off[nout]  = int'(offset);
          obs_last[nout] = last;
        end
        nout++;
        if (last) done = 1;
      end
    end
    en = 1'b1;
    timeout = !done;
  endtask

  task automatic verify(input string tag, input int k, input int f1, input int f2, input int nout);
    int perr, berr, lerr, dup, n, m, e;
    bit seen [KMAX];
    perr = 0; berr = 0; lerr = 0; dup = 0;
    m = k / 8;
    n = (nout < k) ? nout : k;
    chk({tag, "_count"}, 64'(nout), 64'(k));
    for (int i = 0; i < n; i++) begin
      e = gold(k, f1, f2, i);
      if (obs_pi[i] != e) perr++;
      if (obs_bank[i] != e / m || obs_off[i] != e % m) berr++;
      if (obs_last[i] != (i == k - 1)) lerr++;
      if (obs_pi[i] < KMAX) begin
        if (seen[obs_pi[i]]) dup++;
        seen[obs_pi[i]] = 1'b1;
      end
    end
    chk({tag, "_pi_errs"}, 64'(perr), 64'd0);
    chk({tag, "_bankoff_errs"}, 64'(berr), 64'd0);
    chk({tag, "_last_errs"}, 64'(lerr), 64'd0);
    chk({tag, "_dups"}, 64'(dup), 64'd0);
  endtask

  initial begin
    int lat, nout, gaps, frozen, cnt;
    bit to;
    int hist [8];

    rst_n = 1'b0; start = 1'b0; en = 1'b0;
    k_in = '0; f1_in = '0; f2_in = '0;
    #12;
    chk("rst_outs", 64'({out_valid, pi_out, bank_id, offset, last}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();
    en = 1'b1;

    // Test 1: K=40, f1=3, f2=10
    do_start(40, 3, 10);
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    chk("t1_valid_after_start", 64'(out_valid), 64'd0);
    collect(40, 1'b0, lat, nout, gaps, frozen, to);
    chk("t1_timeout", 64'(to), 64'd0);
    chk("t1_latency", 64'(lat), 64'd3);
    chk("t1_pi0", 64'(obs_pi[0]), 64'd0);
    chk("t1_pi1", 64'(obs_pi[1]), 64'd13);
    chk("t1_pi2", 64'(obs_pi[2]), 64'd6);
    chk("t1_pi3", 64'(obs_pi[3]), 64'd19);
    chk("t1_bank1", 64'(obs_bank[1]), 64'd2);
    chk("t1_off1", 64'(obs_off[1]), 64'd3);
    chk("t1_bank3", 64'(obs_bank[3]), 64'd3);
    chk("t1_off3", 64'(obs_off[3]), 64'd4);
    verify("t1", 40, 3, 10, nout);
    tick();
    chk("t1_valid_drop", 64'(out_valid), 64'd0);
    chk("t1_busy_drop", 64'(busy), 64'd0);

    // Test 2: K=6144, f1=263, f2=480
    do_start(6144, 263, 480);
    collect(6144, 1'b0, lat, nout, gaps, frozen, to);
    chk("t2_timeout", 64'(to), 64'd0);
    verify("t2", 6144, 263, 480, nout);
    for (int b = 0; b < 8; b++) hist[b] = 0;
    for (int i = 0; i < nout && i < KMAX; i++) hist[obs_bank[i] & 7]++;
    for (int b = 0; b < 8; b++) chk($sformatf("t2_hist%0d", b), 64'(hist[b]), 64'd768);
    tick();

    // Test 3: random en on K=40
    do_start(40, 3, 10);
    collect(40, 1'b1, lat, nout, gaps, frozen, to);
    chk("t3_timeout", 64'(to), 64'd0);
    chk("t3_frozen_bad", 64'(frozen), 64'd0);
    verify("t3", 40, 3, 10, nout);
    tick();

    // Test 4: restart at i=17 with K=48, f1=7, f2=12
    do_start(40, 3, 10);
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 17; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("t4_pre_count", 64'(cnt), 64'd17);
    do_start(48, 7, 12);
    chk("t4_squash", 64'(out_valid), 64'd0);
    collect(48, 1'b0, lat, nout, gaps, frozen, to);
    chk("t4_timeout", 64'(to), 64'd0);
    chk("t4_latency", 64'(lat), 64'd3);
    chk("t4_pi0", 64'(obs_pi[0]), 64'd0);
    chk("t4_pi1", 64'(obs_pi[1]), 64'd19);
    chk("t4_pi2", 64'(obs_pi[2]), 64'd14);
    verify("t4", 48, 7, 12, nout);
    tick();

    // Test 5: asynchronous reset mid-run
    do_start(40, 3, 10);
    for (int c = 0; c < 12; c++) tick();
    chk("t5_running", 64'({out_valid, busy}), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", 64'({out_valid, pi_out, bank_id, offset, last}), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    do_start(40, 3, 10);
    collect(40, 1'b0, lat, nout, gaps, frozen, to);
    chk("t5_timeout", 64'(to), 64'd0);
    chk("t5_latency", 64'(lat), 64'd3);
    verify("t5", 40, 3, 10, nout);
    tick();

    // Test 6: back-to-back start on the cycle after last
    do_start(40, 3, 10);
    collect(40, 1'b0, lat, nout, gaps, frozen, to);
    chk("t6a_timeout", 64'(to), 64'd0);
    do_start(48, 7, 12);
    chk("t6_busy_at_restart", 64'(busy), 64'd1);
    collect(48, 1'b0, lat, nout, gaps, frozen, to);
    chk("t6_timeout", 64'(to), 64'd0);
    chk("t6_latency", 64'(lat), 64'd3);
    chk("t6_busy_gaps", 64'(gaps), 64'd0);
    verify("t6", 48, 7, 12, nout);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
